// File: rtl/lp_dsp_pkg.sv
// Shared types and width helpers for the low-pass DSP chain (FIR and decimator).
package lp_dsp_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Accumulator width that can hold the sum of decim full-scale samples.
    function automatic int acc_w(input int decim);
        return SAMPLE_W + $clog2(decim);
    endfunction

endpackage

// File: rtl/lp_out_hold.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
module lp_out_hold
    import lp_dsp_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic signed [W-1:0] data,
    output logic signed [W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    input  logic                clr_overrun
);

    // A new result always wins; overrun is flagged when it replaces data the consumer never took.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out       <= data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (load && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lp_decimator.sv
// Boxcar-averaging decimator: sums DECIM samples and emits their mean through lp_out_hold.
// Define LP_DECIM_ROUND_EN to round half toward +inf instead of truncating.
module lp_decimator
    import lp_dsp_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DECIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in,
    input  logic                in_valid,
    output logic signed [W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    input  logic                clr_overrun
);

    localparam int K     = $clog2(DECIM);
    localparam int ACC_W = acc_w(DECIM) + W - SAMPLE_W;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic        [K-1:0]     cnt;
    logic                    last;
    logic signed [W-1:0]     result;

    assign last = in_valid && (cnt == K'(DECIM - 1));
    assign sum  = acc + ACC_W'(in);

`ifdef LP_DECIM_ROUND_EN
    logic signed [ACC_W:0] rsum;
    // One extra bit keeps the half-LSB bias from wrapping at positive full scale.
    assign rsum   = (ACC_W+1)'(sum) + (ACC_W+1)'(1 << (K - 1));
    assign result = W'(rsum >>> K);
`else
    assign result = W'(sum >>> K);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (last) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            acc <= sum;
            cnt <= cnt + K'(1);
        end
    end

    lp_out_hold #(
        .W(W)
    ) u_out_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (last),
        .data       (result),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

endmodule

// File: tb/tb_lp_decimator.sv
// Self-checking bench for lp_decimator (DECIM=4); honours LP_DECIM_ROUND_EN when defined.
module tb_lp_decimator;

    localparam int W     = 16;
    localparam int DECIM = 4;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] in;
    logic                in_valid;
    logic signed [W-1:0] out;
    logic                out_valid;
    logic                out_ready;
    logic                overrun;
    logic                clr_overrun;

    int checks;
    int errors;

    int  frame[$];
    int  expOut;
    bit  expValid;
    bit  expOverrun;

    lp_decimator #(
        .W    (W),
        .DECIM(DECIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .in_valid   (in_valid),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floorDiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int meanOf(input int s);
`ifdef LP_DECIM_ROUND_EN
        return floorDiv(s + DECIM / 2, DECIM);
`else
        return floorDiv(s, DECIM);
`endif
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge.
    task automatic applyStimulus(input int sample, input bit valid, input bit ready,
                                 input bit clr, input bit doReset, input string tag);
        bit newRes;
        int res;
        int s;
        rst         = doReset;
        in          = W'(sample);
        in_valid    = valid;
        out_ready   = ready;
        clr_overrun = clr;

        newRes = 1'b0;
        res    = 0;
        if (doReset) begin
            frame.delete();
            expOut     = 0;
            expValid   = 1'b0;
            expOverrun = 1'b0;
        end else begin
            if (valid) begin
                frame.push_back(sample);
                if (frame.size() == DECIM) begin
                    s = 0;
                    foreach (frame[i]) s += frame[i];
                    res    = meanOf(s);
                    newRes = 1'b1;
                    frame.delete();
                end
            end
            if (newRes) begin
                if (expValid && !ready) expOverrun = 1'b1;
                else if (clr) expOverrun = 1'b0;
                expOut   = res;
                expValid = 1'b1;
            end else begin
                if (clr) expOverrun = 1'b0;
                if (expValid && ready) expValid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        checkOutput({tag, ".out"}, int'(out), expOut);
        checkOutput({tag, ".out_valid"}, int'(out_valid), int'(expValid));
        checkOutput({tag, ".overrun"}, int'(overrun), int'(expOverrun));
    endtask

    task automatic sendFrame(input int a, input int b, input int c, input int d,
                             input bit ready, input string tag);
        applyStimulus(a, 1'b1, ready, 1'b0, 1'b0, tag);
        applyStimulus(b, 1'b1, ready, 1'b0, 1'b0, tag);
        applyStimulus(c, 1'b1, ready, 1'b0, 1'b0, tag);
        applyStimulus(d, 1'b1, ready, 1'b0, 1'b0, tag);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        expOut     = 0;
        expValid   = 1'b0;
        expOverrun = 1'b0;
        rst = 1'b1; in = '0; in_valid = 1'b0; out_ready = 1'b1; clr_overrun = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1000, 1'b1, 1'b1, 1'b0, 1'b1, "reset");

        for (int i = 0; i < 12; i++) applyStimulus(100, 1'b1, 1'b1, 1'b0, 1'b0, "const");

        sendFrame(1, 2, 3, 4, 1'b1, "round_pos");
        sendFrame(-1, -2, -3, -4, 1'b1, "round_neg");
        sendFrame(32767, 32767, 32767, 32767, 1'b1, "max");
        sendFrame(-32768, -32768, -32768, -32768, 1'b1, "min");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, "drain");

        sendFrame(100, 100, 100, 100, 1'b0, "bp_first");
        sendFrame(200, 200, 200, 200, 1'b0, "bp_second");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, "bp_take");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, "bp_clr");
        sendFrame(5, 5, 5, 5, 1'b0, "bp_load");
        applyStimulus(6, 1'b1, 1'b0, 1'b0, 1'b0, "bp_race");
        applyStimulus(6, 1'b1, 1'b0, 1'b0, 1'b0, "bp_race");
        applyStimulus(6, 1'b1, 1'b0, 1'b0, 1'b0, "bp_race");
        applyStimulus(6, 1'b1, 1'b0, 1'b1, 1'b0, "bp_set_wins");
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, "bp_cleanup");

        applyStimulus(8, 1'b1, 1'b1, 1'b0, 1'b0, "gaps");
        applyStimulus(8, 1'b0, 1'b1, 1'b0, 1'b0, "gaps");
        applyStimulus(8, 1'b1, 1'b1, 1'b0, 1'b0, "gaps");
        applyStimulus(8, 1'b0, 1'b1, 1'b0, 1'b0, "gaps");
        applyStimulus(8, 1'b1, 1'b1, 1'b0, 1'b0, "gaps");
        applyStimulus(8, 1'b1, 1'b1, 1'b0, 1'b0, "gaps");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, "gaps_idle");

        applyStimulus(50, 1'b1, 1'b1, 1'b0, 1'b0, "midrst");
        applyStimulus(50, 1'b1, 1'b1, 1'b0, 1'b0, "midrst");
        applyStimulus(50, 1'b1, 1'b1, 1'b0, 1'b1, "midrst_rst");
        sendFrame(10, 10, 10, 10, 1'b1, "midrst_frame");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, "midrst_idle");

        for (int i = 0; i < 600; i++) begin
            applyStimulus(int'($signed(16'($urandom))),
                          ($urandom_range(3, 0) != 0),
                          $urandom_range(1, 0) != 0,
                          ($urandom_range(9, 0) == 0),
                          ($urandom_range(127, 0) == 0),
                          "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lp_decimator.md
Name: lp_decimator

Overview:
- Downstream stage of the low-pass FIR. Consumes one 16-bit signed filtered sample per accepted cycle, boxcar-averages DECIM consecutive samples, and emits one decimated sample per DECIM inputs.
- Output is a registered holding stage with a valid/ready handshake, so a slower consumer (UART packer, DAC formatter) can take samples at its own pace.
- A sticky flag reports results that were overwritten before the consumer accepted them.

Parameters:
- W, 16, sample width for input and output (signed, two's complement).
- DECIM, 4, decimation factor. Power of two, range 2..64. K = log2(DECIM).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  W  filtered sample (signed).
- in_valid  input  1  sample present. Tie to 1 when fed directly from the FIR every cycle.
- out  output  W  decimated sample (signed).
- out_valid  output  1  out holds an unconsumed result.
- out_ready  input  1  consumer accepts out this cycle.
- overrun  output  1  sticky: an unconsumed result was overwritten.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset state: acc=0, cnt=0, out=0, out_valid=0, overrun=0. The accumulator and counter must also be reset (not only the outputs). Reset mid-frame discards the partial sum; the next accepted sample is sample 0 of a new frame.
- Accumulator width is W+K signed, which cannot overflow. The input is sign-extended before adding.
- Each cycle with in_valid=1 and cnt<DECIM-1: acc <= acc+in; cnt <= cnt+1.
- Cycles with in_valid=0: acc and cnt hold.
- In the cycle with in_valid=1 and cnt==DECIM-1:
  - sum = acc+in.
  - result = sum >>> K (arithmetic shift, truncation toward -inf).
  - acc <= 0; cnt <= 0; result is loaded into the out register.
  - The result always fits in W bits. No saturation is needed.
- Latency: out/out_valid become visible on the clock edge that accepts the DECIM-th sample, i.e. in the following cycle.
- Handshake: a transfer occurs when out_valid && out_ready. After a transfer with no new result, out_valid <= 0 and out holds its last value.
- New result with out_valid=0: load it, out_valid <= 1.
- New result with out_valid=1 && out_ready=1: load it, out_valid stays 1, no overrun.
- New result with out_valid=1 && out_ready=0: overwrite (newest wins), out_valid stays 1, overrun <= 1.
- clr_overrun=1 clears overrun. If a new overrun occurs in the same cycle, set wins.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro LP_DECIM_ROUND_EN.
- Defined: result = (sum + 2^(K-1)) >>> K, i.e. round half toward +inf. The addition is done at W+K+1 bits. The result still fits in W bits (max (DECIM·(2^(W-1)-1)+DECIM/2)/DECIM floors to 2^(W-1)-1).
- Undefined: plain truncation, as above.
- All other behaviour is identical either way.

Decomposition:
- Shared package lp_dsp_pkg holds:
  - SAMPLE_W=16;
  - typedef sample_t (signed [SAMPLE_W-1:0]);
  - a constant function for ACC_W = SAMPLE_W+$clog2(DECIM).
- The FIR and this block both import it.
- One natural sub-module: lp_out_hold. It contains the out register, out_valid, handshake and overrun/clr logic, and takes a load strobe plus data.
- The accumulator/counter stays in the top.

Test Plan (DECIM=4, out_ready=1 unless stated):
- Reset: rst=1 for 3 cycles with in=1000, in_valid=1 → out=0, out_valid=0, overrun=0 throughout. After release, the first out_valid appears exactly one cycle after the 4th accepted sample.
- Constant: in=100 every cycle → out_valid is a 1-cycle pulse every 4 cycles with out=100, and overrun stays 0.
- Rounding/sign:
  - in=1,2,3,4 → out=2 (truncated); with LP_DECIM_ROUND_EN, out=3.
  - in=-1,-2,-3,-4 → out=-3; with the macro, out=-2.
- Extremes: in=32767 ×4 → out=32767; in=-32768 ×4 → out=-32768 (both macro settings).
- Backpressure:
  - out_ready=0; frames of 100 then 200 → out=100, out_valid=1 until the second result, then out=200 and overrun=1.
  - out_ready=1 for one cycle → out_valid=0.
  - clr_overrun=1 → overrun=0.
  - clr_overrun in the same cycle as a new overrun → overrun=1.
- Gaps and mid-frame reset:
  - in_valid pattern 1,0,1,0,1,1 with in=8 on valid cycles → exactly one result, out=8.
  - Two samples of 50, then rst for 1 cycle, then 4 samples of 10 → out=10.
